// File: rtl/mux41_arb_pkg.sv
// Shared types and helpers for the mux41 round-robin arbiter.
// Optional build macro used by the top: MUX41_ARB_LOCK_EN.
package mux41_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot2(input logic [SEL_W-1:0] sel);
    logic [N_REQ-1:0] oh;
    case (sel)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mux41_rr_arb_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping mod 4.
module rr_pick4
  import mux41_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Scan ptr+1 .. ptr+4; the lowest offset with a request wins.
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux41_rr_arb.sv
// Round-robin arbiter/sequencer driving a 4:1 mux datapath over valid/ready.
// Build macro MUX41_ARB_LOCK_EN adds a lock input that extends a burst.
module mux41_rr_arb
  import mux41_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             s1,
  output logic             s0,
  output logic [N_REQ-1:0] grant,
  output logic             busy
`ifdef MUX41_ARB_LOCK_EN
  ,
  input  logic             lock
`endif
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  state_t           state_r, state_nx;
  logic [SEL_W-1:0] ptr_r, ptr_nx;
  logic [SEL_W-1:0] sel_r, sel_nx;
  logic [N_REQ-1:0] grant_r, grant_nx;
  logic [CW-1:0]    count_r, count_nx;

  logic [SEL_W-1:0] pick_s;
  logic             any_s;
  logic             beat_s;
  logic             lock_s;
  logic [WIDTH-1:0] mux_s;

`ifdef MUX41_ARB_LOCK_EN
  assign lock_s = lock;
`else
  assign lock_s = 1'b0;
`endif

  rr_pick4 u_pick (
    .req  (req_valid),
    .ptr  (ptr_r),
    .pick (pick_s),
    .any  (any_s)
  );

  // State, pointer, select, grant and beat-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 2'd3;
      sel_r   <= 2'd0;
      grant_r <= 4'b0000;
      count_r <= {CW{1'b0}};
    end else begin
      state_r <= state_nx;
      ptr_r   <= ptr_nx;
      sel_r   <= sel_nx;
      grant_r <= grant_nx;
      count_r <= count_nx;
    end
  end

  // Next-state: arbitrate in IDLE, count beats and decide release in GRANT.
  always_comb begin
    state_nx = state_r;
    ptr_nx   = ptr_r;
    sel_nx   = sel_r;
    grant_nx = grant_r;
    count_nx = count_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_nx = GRANT;
          grant_nx = onehot2(pick_s);
          sel_nx   = pick_s;
          ptr_nx   = pick_s;
          count_nx = {CW{1'b0}};
        end else begin
          state_nx = IDLE;
        end
      end
      GRANT: begin
        if (!req_valid[sel_r]) begin
          state_nx = IDLE;
          grant_nx = 4'b0000;
          count_nx = {CW{1'b0}};
        end else if (beat_s) begin
          if (count_r == LAST && !lock_s) begin
            state_nx = IDLE;
            grant_nx = 4'b0000;
            count_nx = {CW{1'b0}};
          end else if (count_r == LAST) begin
            // Locked beats past the limit park the count at its last value.
            count_nx = count_r;
          end else begin
            count_nx = count_r + CW'(1);
          end
        end else begin
          count_nx = count_r;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = 4'b0000;
        count_nx = {CW{1'b0}};
      end
    endcase
  end

  // 4:1 data select driven by the registered mux select.
  always_comb begin
    case (sel_r)
      2'd0:    mux_s = i0;
      2'd1:    mux_s = i1;
      2'd2:    mux_s = i2;
      2'd3:    mux_s = i3;
      default: mux_s = {WIDTH{1'b0}};
    endcase
  end

  // Handshake outputs are live only while a grant is held.
  always_comb begin
    out_valid = 1'b0;
    out_data  = {WIDTH{1'b0}};
    req_ready = 4'b0000;
    if (state_r == GRANT) begin
      out_valid = req_valid[sel_r];
      out_data  = mux_s;
      req_ready = onehot2(sel_r) & {N_REQ{out_ready}};
    end else begin
      out_valid = 1'b0;
    end
  end

  assign beat_s = out_valid & out_ready;
  assign s1     = sel_r[1];
  assign s0     = sel_r[0];
  assign grant  = grant_r;
  assign busy   = (state_r == GRANT);

endmodule

// File: tb/tb_mux41_rr_arb.sv
// Directed self-checking bench for mux41_rr_arb (lock test needs MUX41_ARB_LOCK_EN).
module tb_mux41_rr_arb;

  logic       clk;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [7:0] i0, i1, i2, i3;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       s1, s0;
  logic [3:0] grant;
  logic       busy;
`ifdef MUX41_ARB_LOCK_EN
  logic       lock;
`endif

  int checks;
  int errors;
  logic [7:0] dat [4];

  mux41_rr_arb #(.WIDTH(8), .BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .i0        (i0),
    .i1        (i1),
    .i2        (i2),
    .i3        (i3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .s1        (s1),
    .s0        (s0),
    .grant     (grant),
    .busy      (busy)
`ifdef MUX41_ARB_LOCK_EN
    ,
    .lock      (lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'b0000;
    out_ready = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
    cyc();
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || req_ready !== 4'b0000 || out_data !== 8'h00) begin
      errors++; $display("FAIL reset_idle busy=%b req_ready=%b out_data=%h exp 0 0000 00", busy, req_ready, out_data);
    end
    cyc();
    @(negedge clk);
    checks++; if (grant !== 4'b0001 || out_data !== 8'h11) begin
      errors++; $display("FAIL reset_first_grant grant=%b data=%h exp 0001 11", grant, out_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency out_valid=%b exp 0", out_valid); end
    for (int b = 0; b < 4; b++) begin
      cyc();
      @(negedge clk);
      checks++; if (grant !== 4'b0100 || {s1, s0} !== 2'b10 || out_data !== 8'hA5 || out_valid !== 1'b1 || req_ready !== 4'b0100) begin
        errors++; $display("FAIL single_beat%0d grant=%b sel=%b data=%h valid=%b ready=%b exp 0100 10 a5 1 0100", b, grant, {s1, s0}, out_data, out_valid, req_ready);
      end
    end
    cyc();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || grant !== 4'b0000 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL single_bubble busy=%b grant=%b valid=%b data=%h exp 0 0000 0 00", busy, grant, out_valid, out_data);
    end
    cyc();
    @(negedge clk);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_regrant grant=%b exp 0100", grant); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    int g;
    do_reset();
    req_valid = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      exp_g = 4'b0001 << g;
      for (int b = 0; b < 4; b++) begin
        cyc();
        @(negedge clk);
        checks++; if (grant !== exp_g || out_data !== dat[g]) begin
          errors++; $display("FAIL fair_g%0d_b%0d grant=%b data=%h exp %b %h", k, b, grant, out_data, exp_g, dat[g]);
        end
      end
      cyc();
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fair_bubble%0d busy=%b exp 0", k, busy); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_valid = 4'b0010; out_ready = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL stall_pre grant=%b exp 0010", grant); end
    cyc();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (grant !== 4'b0010 || out_data !== 8'h22 || req_ready !== 4'b0000 || out_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d grant=%b data=%h ready=%b valid=%b exp 0010 22 0000 1", k, grant, out_data, req_ready, out_valid);
      end
      cyc();
    end
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      checks++; if (grant !== 4'b0010 || req_ready !== 4'b0010) begin
        errors++; $display("FAIL stall_resume%0d grant=%b ready=%b exp 0010 0010", b, grant, req_ready);
      end
      cyc();
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_release busy=%b exp 0", busy); end
  endtask

  task automatic test_valid_drop();
    do_reset();
    req_valid = 4'b1000; out_ready = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    checks++; if (grant !== 4'b1000 || out_data !== 8'h44) begin
      errors++; $display("FAIL drop_grant grant=%b data=%h exp 1000 44", grant, out_data);
    end
    cyc();
    req_valid = 4'b0101;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || grant !== 4'b1000) begin
      errors++; $display("FAIL drop_cycle valid=%b grant=%b exp 0 1000", out_valid, grant);
    end
    cyc();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle busy=%b exp 0", busy); end
    cyc();
    @(negedge clk);
    checks++; if (grant !== 4'b0001 || {s1, s0} !== 2'b00) begin
      errors++; $display("FAIL drop_next grant=%b sel=%b exp 0001 00", grant, {s1, s0});
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    req_valid = 4'b0001; out_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL abort_ready_pre ready=%b exp 0001", req_ready); end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL abort_reset grant=%b busy=%b ready=%b exp 0000 0 0000", grant, busy, req_ready);
    end
    for (int b = 0; b < 4; b++) begin
      cyc();
      @(negedge clk);
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL abort_beat%0d grant=%b exp 0001", b, grant); end
    end
    cyc();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_release busy=%b exp 0", busy); end
  endtask

`ifdef MUX41_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    lock = 1'b0;
    req_valid = 4'b0001; out_ready = 1'b1;
    for (int b = 1; b <= 7; b++) begin
      cyc();
      lock = (b < 7) ? 1'b1 : 1'b0;
      @(negedge clk);
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL lock_beat%0d grant=%b exp 0001", b, grant); end
    end
    cyc();
    lock = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_release busy=%b exp 0", busy); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'hA5; dat[3] = 8'h44;
    i0 = dat[0]; i1 = dat[1]; i2 = dat[2]; i3 = dat[3];
    rst = 1'b1; req_valid = 4'b0000; out_ready = 1'b0;
`ifdef MUX41_ARB_LOCK_EN
    lock = 1'b0;
`endif
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_valid_drop();
    test_reset_abort();
`ifdef MUX41_ARB_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
